// File: rtl/fc_fold_sequencer.sv
// fc_fold_sequencer: control-and-collect stage for the folded FC datapath.
// Runs one inference per accepted start: for each fold it pulses the
// accumulator clear, streams STREAM_LEN enable cycles, waits PIPE_LAT settle
// cycles, then captures the clipped MAC slice into the result vector. The full
// DIM_OUT vector is offered on a valid/ready handshake.
// Optional build macro FC_SAT_FLAG_EN adds out_sat, one flag per element
// marking values sitting on a clip rail (all zeros or all ones).
module fc_fold_sequencer #(
   parameter int DIM_OUT    = 8,
   parameter int FOLD       = 2,
   parameter int LOG_FOLD   = 1,
   parameter int INWD       = 8,
   parameter int STREAM_LEN = 256,
   parameter int PIPE_LAT   = 2
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             start,
   output logic                             busy,
   output logic                             fc_enable,
   output logic                             fc_toggle,
   output logic [LOG_FOLD-1:0]              fc_mux_select,
   input  logic [(DIM_OUT/FOLD)*INWD-1:0]   mac_in,
   output logic                             out_valid,
   input  logic                             out_ready,
`ifdef FC_SAT_FLAG_EN
   output logic [DIM_OUT-1:0]               out_sat,
`endif
   output logic [DIM_OUT*INWD-1:0]          out_data
);

   localparam int SLICE   = DIM_OUT / FOLD;
   localparam int SLICE_W = SLICE * INWD;
   // One counter serves both the streaming and the settle phase.
   localparam int CNT_MAX = (STREAM_LEN > PIPE_LAT) ? STREAM_LEN : PIPE_LAT;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   localparam logic [CNT_W-1:0]    RUN_LAST   = CNT_W'(STREAM_LEN - 1);
   localparam logic [CNT_W-1:0]    DRAIN_LAST = CNT_W'((PIPE_LAT > 0) ? PIPE_LAT - 1 : 0);
   localparam logic [LOG_FOLD-1:0] FOLD_LAST  = LOG_FOLD'(FOLD - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_RUN,
      S_DRAIN,
      S_CAPTURE,
      S_DONE
   } state_t;

   state_t                    state_q, state_d;
   logic [CNT_W-1:0]          cnt_q, cnt_d;
   logic [LOG_FOLD-1:0]       fold_q, fold_d;
   logic [DIM_OUT*INWD-1:0]   data_d;
`ifdef FC_SAT_FLAG_EN
   logic [DIM_OUT-1:0]        sat_d;

   // True when an element sits on either clip rail.
   function automatic logic is_rail(input logic [INWD-1:0] v);
      return (v == '0) || (v == '1);
   endfunction
`endif

   // The fold index doubles as the datapath fold select, so it is stable from
   // CLEAR through CAPTURE of each fold.
   assign fc_mux_select = fold_q;

   // Next-state, counter, fold and capture logic
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      fold_d  = fold_q;
      data_d  = out_data;
`ifdef FC_SAT_FLAG_EN
      sat_d   = out_sat;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_CLEAR;
               fold_d  = '0;
            end
         end
         S_CLEAR: begin
            state_d = S_RUN;
            cnt_d   = '0;
         end
         S_RUN: begin
            if (cnt_q == RUN_LAST) begin
               cnt_d   = '0;
               state_d = (PIPE_LAT == 0) ? S_CAPTURE : S_DRAIN;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_DRAIN: begin
            if (cnt_q == DRAIN_LAST) begin
               cnt_d   = '0;
               state_d = S_CAPTURE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_CAPTURE: begin
            data_d[int'(fold_q)*SLICE_W +: SLICE_W] = mac_in;
`ifdef FC_SAT_FLAG_EN
            for (int k = 0; k < SLICE; k++) begin
               sat_d[int'(fold_q)*SLICE + k] = is_rail(mac_in[k*INWD +: INWD]);
            end
`endif
            if (fold_q == FOLD_LAST) begin
               state_d = S_DONE;
            end else begin
               fold_d  = fold_q + LOG_FOLD'(1);
               state_d = S_CLEAR;
            end
         end
         S_DONE: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State register, phase counter and fold index
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         fold_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         fold_q  <= fold_d;
      end
   end

   // Control outputs registered from the next state so they align with it
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy      <= 1'b0;
         fc_enable <= 1'b0;
         fc_toggle <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         busy      <= (state_d != S_IDLE);
         fc_enable <= (state_d == S_RUN);
         fc_toggle <= (state_d == S_CLEAR);
         out_valid <= (state_d == S_DONE);
      end
   end

   // Result vector; a reset discards any partially assembled result
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_data <= '0;
`ifdef FC_SAT_FLAG_EN
         out_sat  <= '0;
`endif
      end else begin
         out_data <= data_d;
`ifdef FC_SAT_FLAG_EN
         out_sat  <= sat_d;
`endif
      end
   end

endmodule

// File: doc/fc_fold_sequencer.md
Name: fc_fold_sequencer

Overview:
- Downstream control-and-collect stage for the folded FC datapath.
- Sequences one full inference: clears neuron accumulators, streams bitstream cycles, and steps the fold select.
- Captures each fold's clipped MAC slice and assembles the full DIM_OUT result vector.
- Presents the result on a valid/ready handshake to the next layer.

Parameters:
- DIM_OUT, 8: total output neurons; must be divisible by FOLD.
- FOLD, 2: number of time-multiplexed output groups; ≥1.
- LOG_FOLD, 1: width of fold select, equal to clog2(FOLD), minimum 1.
- INWD, 8: output element width.
- STREAM_LEN, 256: bitstream cycles per fold, i.e. cycles with fc_enable high; ≥1.
- PIPE_LAT, 2: settle cycles after streaming, before capture; ≥0.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- start  in  1  request a new inference; accepted only in IDLE.
- busy  out  1  high in every state except IDLE.
- fc_enable  out  1  drives FC enable.
- fc_toggle  out  1  drives FC toggle (accumulator clear pulse).
- fc_mux_select  out  LOG_FOLD  drives FC fold select.
- mac_in  in  (DIM_OUT/FOLD)*INWD  mac_out_clipped from FC.
- out_valid  out  1  result vector valid.
- out_ready  in  1  consumer accepts result.
- out_data  out  DIM_OUT*INWD  assembled result; element k at bits [k*INWD +: INWD].

Behaviour:
- Reset (async, active-high): state=IDLE; busy, fc_enable, fc_toggle, out_valid = 0; fc_mux_select = 0; out_data = 0; counters = 0.
- FSM states: IDLE, CLEAR, RUN, DRAIN, CAPTURE, DONE. All outputs are registered.
- IDLE:
  - start=1 → CLEAR; fold index = 0.
  - start in any other state is ignored; there is no queuing.
- CLEAR (1 cycle): fc_toggle=1, fc_enable=0 → RUN.
- RUN:
  - fc_enable=1 for exactly STREAM_LEN consecutive cycles.
  - Cycle counter counts 0..STREAM_LEN-1; at terminal count → DRAIN, or → CAPTURE if PIPE_LAT=0.
- DRAIN: fc_enable=0 for PIPE_LAT cycles → CAPTURE.
- CAPTURE (1 cycle):
  - Latch mac_in into out_data elements [f*DIM_OUT/FOLD +: DIM_OUT/FOLD], where f is the current fold.
  - Elements outside that slice hold their values.
  - If f==FOLD-1 → DONE; else f+1, fc_mux_select=f+1, → CLEAR.
- fc_mux_select is stable for the whole CLEAR..CAPTURE span of its fold.
- Fold index wraps to 0 only on a new start; it never wraps mid-run.
- DONE:
  - out_valid=1; out_data held stable.
  - out_valid=1 && out_ready=1 → IDLE; out_valid drops the next cycle.
  - out_data retains its value until overwritten by the next run.
  - start in the handshake cycle is ignored; busy is still 1 that cycle.
- Latency: result valid exactly FOLD*(1+STREAM_LEN+PIPE_LAT+1) cycles after the start-accept edge.
- Backpressure: may stall indefinitely in DONE; FC outputs stay idle (enable=0, toggle=0) during the stall.
- Reset mid-run: immediate return to IDLE; partial out_data cleared to 0; no out_valid emitted.
- FOLD=1: fc_mux_select stays 0; single pass.

Optional Feature:
- Macro: FC_SAT_FLAG_EN.
- Defined:
  - Extra output port out_sat, DIM_OUT bits, with bit k = 1 iff captured element k is 0 or 2^INWD-1 (clip rail).
  - Updated in CAPTURE alongside its slice; reset 0; valid under the same handshake as out_data.
- Undefined: no port and no logic; all other behaviour identical.

Test Plan:
- Default params, mac_in=8'h11 repeated, single start:
  - toggle pulses at cycles 1 and 261; fc_enable high for 256 cycles per fold; fc_mux_select 0 then 1.
  - out_valid rises 520 cycles after start accept; out_data = all 8'h11.
- Fold separation: mac_in=8'hAA during fold 0, 8'h55 during fold 1, out_ready=1 → elements 0-3 = 8'hAA, elements 4-7 = 8'h55; IDLE the next cycle.
- Backpressure: out_ready=0 for 50 cycles after out_valid → out_valid and out_data stable; fc_enable=0 throughout; start pulses ignored; IDLE one cycle after out_ready=1.
- Reset mid-run: assert rst at cycle 130 of fold 1 → immediately busy=0, fc_enable=0, out_data=0; a new start then completes normally in 520 cycles.
- Start spam: start held high continuously → back-to-back runs, each 520 cycles plus 1 handshake cycle plus 1 IDLE cycle, with no overlap.
- FC_SAT_FLAG_EN defined, fold 0 mac_in elements {00,FF,7F,01} → out_sat[3:0]=4'b0011.
